// File: rtl/bsg_mcl_request_arbiter.sv
// Round-robin, credit-gated arbiter feeding one registered endpoint request channel.
// Optional per-requester grant counters are built when BSG_MCL_ARB_PERF_CNT_EN is defined.
module bsg_mcl_request_arbiter #(
    parameter int num_req_p         = 4,
    parameter int fifo_width_p      = 128,
    parameter int max_out_credits_p = 16,
    parameter int op_lsb_p          = 32,
    localparam int cw_lp            = $clog2(max_out_credits_p + 1),
    localparam int id_w_lp          = $clog2(num_req_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p*fifo_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]              req_rdy_o,
    output logic                              out_v_o,
    output logic [fifo_width_p-1:0]           out_data_o,
    input  logic                              out_rdy_i,
    output logic [id_w_lp-1:0]                out_id_o,
    input  logic                              credit_return_i,
    input  logic [31:0]                       rcv_vacancy_i,
    output logic [cw_lp-1:0]                  out_credits_o,
    output logic                              credit_err_o,
    output logic [num_req_p*32-1:0]           perf_grant_cnt_o
);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [fifo_width_p-1:0] r_data;
    logic [id_w_lp-1:0]      r_id;
    logic [id_w_lp-1:0]      r_last;
    logic [cw_lp-1:0]        r_credits;
    logic [cw_lp-1:0]        w_credits_next;
    logic                    r_err;
    logic                    w_credit_sat;

    logic                    w_has_credit;
    logic                    w_vac_ok;
    logic                    w_can_grant;
    logic                    w_grant_v;
    logic [id_w_lp-1:0]      w_grant_id;
    logic [num_req_p-1:0]    w_eligible;
    logic [fifo_width_p-1:0] w_word [num_req_p];
    logic [id_w_lp:0]        w_sum  [num_req_p];
    logic [id_w_lp-1:0]      w_cand [num_req_p];

    assign w_has_credit = (r_credits != '0);
    assign w_vac_ok     = (rcv_vacancy_i >= 32'(max_out_credits_p));
    assign w_can_grant  = (r_state == ST_EMPTY) || out_rdy_i;

    genvar gi;
    generate
        for (gi = 0; gi < num_req_p; gi++) begin : g_req
            assign w_word[gi]     = req_data_i[gi*fifo_width_p +: fifo_width_p];
            // Loads are held back until the host receive FIFO can absorb a full credit window.
            assign w_eligible[gi] = req_v_i[gi] & w_has_credit &
                                    ((w_word[gi][op_lsb_p +: 8] != 8'h00) | w_vac_ok);
            // Candidate gi is the (gi+1)-th requester after the last winner, modulo num_req_p.
            assign w_sum[gi]      = {1'b0, r_last} + (id_w_lp+1)'(gi + 1);
            assign w_cand[gi]     = (w_sum[gi] >= (id_w_lp+1)'(num_req_p))
                                  ? id_w_lp'(w_sum[gi] - (id_w_lp+1)'(num_req_p))
                                  : w_sum[gi][id_w_lp-1:0];
            assign req_rdy_o[gi]  = w_grant_v & (w_grant_id == id_w_lp'(gi));
        end
    endgenerate

    // Scan from the farthest candidate back so the nearest eligible one is written last.
    always_comb begin
        w_grant_v  = 1'b0;
        w_grant_id = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            if (w_eligible[w_cand[k]]) begin
                w_grant_v  = 1'b1;
                w_grant_id = w_cand[k];
            end
        end
        if (!w_can_grant) begin
            w_grant_v = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_grant_v) w_state_next = ST_FULL;
            ST_FULL: begin
                if (w_grant_v)      w_state_next = ST_FULL;
                else if (out_rdy_i) w_state_next = ST_EMPTY;
            end
            default:                w_state_next = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_v_o = (r_state == ST_FULL);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_data <= '0;
            r_id   <= '0;
            r_last <= id_w_lp'(num_req_p - 1);
        end else if (w_grant_v) begin
            r_data <= w_word[w_grant_id];
            r_id   <= w_grant_id;
            r_last <= w_grant_id;
        end
    end

    assign w_credit_sat = credit_return_i & ~w_grant_v &
                          (r_credits == cw_lp'(max_out_credits_p));

    always_comb begin
        w_credits_next = r_credits;
        case ({w_grant_v, credit_return_i})
            2'b10:   w_credits_next = r_credits - cw_lp'(1);
            2'b01:   w_credits_next = w_credit_sat ? r_credits : r_credits + cw_lp'(1);
            default: w_credits_next = r_credits;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_credits <= cw_lp'(max_out_credits_p);
            r_err     <= 1'b0;
        end else begin
            r_credits <= w_credits_next;
            r_err     <= r_err | w_credit_sat;
        end
    end

    assign out_data_o    = r_data;
    assign out_id_o      = r_id;
    assign out_credits_o = r_credits;
    assign credit_err_o  = r_err;

`ifdef BSG_MCL_ARB_PERF_CNT_EN
    generate
        for (gi = 0; gi < num_req_p; gi++) begin : g_perf
            logic [31:0] r_cnt;
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    r_cnt <= '0;
                end else if (req_rdy_o[gi]) begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
            assign perf_grant_cnt_o[gi*32 +: 32] = r_cnt;
        end
    endgenerate
`else
    assign perf_grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_mcl_request_arbiter.sv
// Randomized and directed bench for bsg_mcl_request_arbiter against a queue-free behavioural model.
module tb_bsg_mcl_request_arbiter;
    localparam int N   = 4;
    localparam int W   = 128;
    localparam int C   = 16;
    localparam int OPL = 32;
`ifdef BSG_MCL_ARB_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_v = '0;
    logic [W-1:0]   words [N];
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_rdy;
    logic           out_v;
    logic [W-1:0]   out_data;
    logic           out_rdy = 1'b0;
    logic [1:0]     out_id;
    logic           credit_return = 1'b0;
    logic [31:0]    vac = '0;
    logic [4:0]     out_credits;
    logic           credit_err;
    logic [N*32-1:0] perf;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the arbiter's observable state.
    bit          m_full;
    logic [W-1:0] m_data;
    int          m_id, m_last, m_credits;
    bit          m_err;
    int unsigned m_cnt [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pack
            assign req_data[gi*W +: W] = words[gi];
        end
    endgenerate

    bsg_mcl_request_arbiter #(
        .num_req_p(N), .fifo_width_p(W), .max_out_credits_p(C), .op_lsb_p(OPL)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_data_i(req_data),
        .req_rdy_o(req_rdy), .out_v_o(out_v), .out_data_o(out_data), .out_rdy_i(out_rdy),
        .out_id_o(out_id), .credit_return_i(credit_return), .rcv_vacancy_i(vac),
        .out_credits_o(out_credits), .credit_err_o(credit_err), .perf_grant_cnt_o(perf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] rand_word(bit load);
        logic [W-1:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        w[OPL +: 8] = load ? 8'h00 : 8'($urandom_range(1, 255));
        return w;
    endfunction

    function automatic int model_grant();
        if (m_credits == 0) return -1;
        if (m_full && !out_rdy) return -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (req_v[i] && (words[i][OPL +: 8] != 8'h00 || vac >= 32'(C))) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_rdy();
        int g;
        logic [N-1:0] r;
        g = model_grant();
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_full = 0; m_data = '0; m_id = 0; m_last = N - 1; m_credits = C; m_err = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic step();
        int g;
        logic [W-1:0] w;
        bit ret, rdy;
        g = model_grant();
        w = (g >= 0) ? words[g] : '0;
        ret = credit_return;
        rdy = out_rdy;
        @(posedge clk);
        if (g >= 0) begin
            m_full = 1; m_data = w; m_id = g; m_last = g; m_cnt[g]++;
        end else if (m_full && rdy) begin
            m_full = 0;
        end
        if (g >= 0 && !ret) m_credits--;
        else if (g < 0 && ret) begin
            if (m_credits == C) m_err = 1;
            else m_credits++;
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_v = '0; out_rdy = 1'b0; credit_return = 1'b0; vac = '0;
        for (int i = 0; i < N; i++) words[i] = rand_word(0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_v = '1; out_rdy = 1'b1; credit_return = 1'b0; vac = '0;
        for (int i = 0; i < N; i++) words[i] = rand_word(0);
        model_reset();
        @(posedge clk); #1;
        checks++; if (out_v !== 1'b0) begin errors++; $display("FAIL reset_out_v got %b exp 0", out_v); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL reset_out_id got %0d exp 0", out_id); end
        checks++; if (out_credits !== 5'd16) begin errors++; $display("FAIL reset_credits got %0d exp 16", out_credits); end
        checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", credit_err); end
        checks++; if (perf !== '0) begin errors++; $display("FAIL reset_perf got %h exp 0", perf); end
        reset_n = 1'b1;
        #1;
        // First grant after reset goes to requester 0 since last_grant starts at N-1.
        checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b exp 0001", req_rdy); end
        step();
        $display("test_reset done");
    endtask

    task automatic test_round_robin();
        logic [N-1:0] e;
        do_reset();
        req_v = '1; out_rdy = 1'b1; credit_return = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            e = 4'b0001 << (k % N);
            checks++; if (req_rdy !== e) begin errors++; $display("FAIL rr_grant cyc %0d got %b exp %b", k, req_rdy, e); end
            if (k > 0) begin
                checks++; if (out_v !== 1'b1 || out_id !== 2'((k - 1) % N)) begin
                    errors++; $display("FAIL rr_out cyc %0d got v=%b id=%0d exp v=1 id=%0d", k, out_v, out_id, (k - 1) % N);
                end
            end
            step();
        end
        $display("test_round_robin done");
    endtask

    task automatic test_credits();
        do_reset();
        req_v = '1; out_rdy = 1'b1; credit_return = 1'b0;
        repeat (16) step();
        #1;
        checks++; if (out_credits !== 5'd0) begin errors++; $display("FAIL cred_exhaust got %0d exp 0", out_credits); end
        checks++; if (req_rdy !== '0) begin errors++; $display("FAIL cred_rdy0 got %b exp 0000", req_rdy); end
        step();
        checks++; if (out_v !== 1'b0) begin errors++; $display("FAIL cred_drain got v=%b exp 0", out_v); end
        credit_return = 1'b1;
        #1;
        checks++; if (req_rdy !== '0) begin errors++; $display("FAIL cred_same_cycle got %b exp 0000", req_rdy); end
        step();
        credit_return = 1'b0;
        #1;
        checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL cred_one_grant got %b exp 0001", req_rdy); end
        step();
        #1;
        checks++; if (out_v !== 1'b1 || out_id !== 2'd0 || out_credits !== 5'd0 || req_rdy !== '0) begin
            errors++; $display("FAIL cred_after got v=%b id=%0d cr=%0d rdy=%b exp v=1 id=0 cr=0 rdy=0000", out_v, out_id, out_credits, req_rdy);
        end
        step();
        $display("test_credits done");
    endtask

    task automatic test_load_op();
        bit found;
        do_reset();
        words[1] = rand_word(1);
        vac = 32'd15; req_v = '1; out_rdy = 1'b1; credit_return = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            checks++; if (req_rdy[1] !== 1'b0 || req_rdy !== model_rdy()) begin
                errors++; $display("FAIL load_blocked cyc %0d got %b exp %b", k, req_rdy, model_rdy());
            end
            step();
        end
        vac = 32'd16;
        found = 0;
        for (int k = 0; k < 4 && !found; k++) begin
            #1;
            if (req_rdy[1] === 1'b1) found = 1;
            step();
        end
        checks++; if (!found) begin errors++; $display("FAIL load_release got no grant exp grant to 1"); end
        $display("test_load_op done");
    endtask

    task automatic test_stall();
        logic [W-1:0] held;
        do_reset();
        req_v = '1; out_rdy = 1'b1;
        held = words[0];
        step();
        out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) words[i] = rand_word(0);
            #1;
            checks++; if (out_v !== 1'b1 || out_data !== held || out_id !== 2'd0) begin
                errors++; $display("FAIL stall_hold cyc %0d got v=%b id=%0d data=%h exp v=1 id=0 data=%h", k, out_v, out_id, out_data, held);
            end
            checks++; if (req_rdy !== '0 || out_credits !== 5'd15) begin
                errors++; $display("FAIL stall_rdy cyc %0d got rdy=%b cr=%0d exp rdy=0000 cr=15", k, req_rdy, out_credits);
            end
            step();
        end
        out_rdy = 1'b1;
        #1;
        checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL stall_resume got %b exp 0010", req_rdy); end
        step();
        $display("test_stall done");
    endtask

    task automatic test_credit_overflow();
        do_reset();
        credit_return = 1'b1;
        #1;
        step();
        credit_return = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (out_credits !== 5'd16 || credit_err !== 1'b1) begin
                errors++; $display("FAIL overflow cyc %0d got cr=%0d err=%b exp cr=16 err=1", k, out_credits, credit_err);
            end
            step();
        end
        do_reset();
        #1;
        checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL overflow_clear got %b exp 0", credit_err); end
        $display("test_credit_overflow done");
    endtask

    task automatic test_reset_mid();
        int unsigned e;
        do_reset();
        req_v = '1; out_rdy = 1'b1;
        repeat (6) step();
        out_rdy = 1'b0;
        #1;
        checks++; if (out_v !== 1'b1) begin errors++; $display("FAIL mid_full got %b exp 1", out_v); end
        for (int i = 0; i < N; i++) begin
            e = PERF_ON ? m_cnt[i] : 32'd0;
            checks++; if (perf[i*32 +: 32] !== e) begin errors++; $display("FAIL mid_perf[%0d] got %0d exp %0d", i, perf[i*32 +: 32], e); end
        end
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (out_v !== 1'b0 || out_data !== '0 || out_id !== 2'd0) begin
            errors++; $display("FAIL mid_reset_out got v=%b id=%0d data=%h exp 0", out_v, out_id, out_data);
        end
        checks++; if (out_credits !== 5'd16 || credit_err !== 1'b0 || perf !== '0) begin
            errors++; $display("FAIL mid_reset_state got cr=%0d err=%b perf=%h exp cr=16 err=0 perf=0", out_credits, credit_err, perf);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        out_rdy = 1'b1;
        #1;
        checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL mid_regrant got %b exp 0001", req_rdy); end
        step();
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int unsigned e;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            req_v = 4'($urandom);
            for (int i = 0; i < N; i++) words[i] = rand_word($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0: vac = 32'd15;
                1: vac = 32'd16;
                default: vac = $urandom;
            endcase
            out_rdy = ($urandom_range(0, 3) != 0);
            credit_return = ($urandom_range(0, 2) == 0);
            #1;
            checks++; if (req_rdy !== model_rdy()) begin errors++; $display("FAIL rnd_rdy cyc %0d got %b exp %b", k, req_rdy, model_rdy()); end
            checks++; if (out_v !== m_full) begin errors++; $display("FAIL rnd_v cyc %0d got %b exp %b", k, out_v, m_full); end
            checks++; if (out_data !== m_data || out_id !== 2'(m_id)) begin
                errors++; $display("FAIL rnd_data cyc %0d got id=%0d data=%h exp id=%0d data=%h", k, out_id, out_data, m_id, m_data);
            end
            checks++; if (out_credits !== 5'(m_credits) || credit_err !== m_err) begin
                errors++; $display("FAIL rnd_credit cyc %0d got cr=%0d err=%b exp cr=%0d err=%b", k, out_credits, credit_err, m_credits, m_err);
            end
            for (int i = 0; i < N; i++) begin
                e = PERF_ON ? m_cnt[i] : 32'd0;
                checks++; if (perf[i*32 +: 32] !== e) begin errors++; $display("FAIL rnd_perf[%0d] cyc %0d got %0d exp %0d", i, k, perf[i*32 +: 32], e); end
            end
            step();
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_credits();
        test_load_op();
        test_stall();
        test_credit_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
